knightrider_monitor: RTL and testbench

//   Receive-side checker for the Knight Rider LED bus. Samples the one-hot leds

---
 rtl/knightrider_monitor_if.sv | 28 ++
 rtl/knightrider_monitor.sv | 142 ++++++++++++++
 tb/tb_knightrider_monitor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/knightrider_monitor_if.sv
// LED bus between the Knight Rider sweep generator and its receive-side monitor.
// The generator side drives en/clr/leds; the monitor reports what it recovered.
interface knightrider_monitor_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    localparam int POS_W = $clog2(N);

    logic             en;
    logic             clr;
    logic [N-1:0]     leds;
    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             dir;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] sweep_cnt;

    modport master (
        output en, clr, leds,
        input  pos, pos_valid, dir, err, err_code, sweep_cnt
    );

    modport slave (
        input  en, clr, leds,
        output pos, pos_valid, dir, err, err_code, sweep_cnt
    );
endinterface

// File: rtl/knightrider_monitor.sv
// Knight Rider LED bus checker: recovers position/direction from the one-hot
// word, enforces the single-step bounce policy and counts end arrivals.
module knightrider_monitor #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    knightrider_monitor_if.slave  bus
);
    localparam int POS_W = $clog2(N);
    localparam logic [POS_W-1:0] P_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] P_LAST = POS_W'(N - 1);
    localparam logic [N-1:0]     L_ONE  = N'(1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [POS_W-1:0] idx;
    logic             onehot;
    logic [POS_W-1:0] exp_pos;
    logic             exp_dir;
    logic             sync_ok;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.leds[i]) idx = idx | POS_W'(i);
        end
        onehot = (bus.leds != '0) &&
                 ((bus.leds & (bus.leds - L_ONE)) == '0);
    end

    // Bounce policy: the ends force a reversal, elsewhere keep going.
    always_comb begin
        exp_pos = '0;
        exp_dir = dir_q;
        if (pos_q == P_LAST) begin
            exp_pos = P_LAST - P_ONE;
            exp_dir = 1'b0;
        end else if (pos_q == '0) begin
            exp_pos = P_ONE;
            exp_dir = 1'b1;
        end else begin
            exp_pos = dir_q ? pos_q + P_ONE : pos_q - P_ONE;
        end
        sync_ok = ((pos_q != P_LAST) && (idx == pos_q + P_ONE)) ||
                  ((pos_q != '0) && (idx == pos_q - P_ONE));
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        dir_d       = dir_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        cnt_d       = cnt_q;
        if (bus.clr) begin
            state_d     = IDLE;
            pos_valid_d = 1'b0;
            err_d       = 1'b0;
            err_code_d  = 2'b00;
            cnt_d       = '0;
        end else if (bus.en) begin
            unique case (state_q)
                IDLE: begin
                    if (onehot) begin
                        pos_d       = idx;
                        pos_valid_d = 1'b1;
                        state_d     = SYNC;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        state_d    = FAULT;
                    end
                end
                SYNC, TRACK: begin
                    if (!onehot) begin
                        err_d       = 1'b1;
                        err_code_d  = 2'b01;
                        pos_valid_d = 1'b0;
                        state_d     = FAULT;
                    end else if (state_q == SYNC && sync_ok) begin
                        pos_d   = idx;
                        dir_d   = idx > pos_q;
                        state_d = TRACK;
                    end else if (state_q == TRACK && idx == exp_pos) begin
                        pos_d = idx;
                        dir_d = exp_dir;
                        if ((idx == '0 || idx == P_LAST) && cnt_q != '1)
                            cnt_d = cnt_q + C_ONE;
                    end else begin
                        err_d       = 1'b1;
                        err_code_d  = 2'b10;
                        pos_valid_d = 1'b0;
                        state_d     = FAULT;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.pos       = pos_q;
    assign bus.pos_valid = pos_valid_q;
    assign bus.dir       = dir_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.sweep_cnt = cnt_q;
endmodule

// File: tb/tb_knightrider_monitor.sv
// Randomized bench for knightrider_monitor against a step-rule model
// plus directed bounce, dwell, saturation and reset scenarios.
module tb_knightrider_monitor;
    localparam int N = 8;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic arst = 1'b0;

    knightrider_monitor_if #(.N(N), .CNT_W(CNT_W)) bus ();

    knightrider_monitor #(.N(N), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // model: phase 0 idle, 1 first sample held, 2 tracking, 3 faulted
    int m_phase, m_pos, m_dir, m_pv, m_err, m_code, m_cnt;
    int gpos, gdir;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_dir = 0; m_pv = 0;
        m_err = 0; m_code = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit en, input bit clr,
                              input logic [7:0] l);
        int ones, idx, step, want;
        bit ok;
        ones = $countones(l);
        idx = 0;
        for (int i = 0; i < N; i++) if (l[i]) idx = i;
        if (clr) begin
            m_phase = 0; m_pv = 0; m_err = 0; m_code = 0; m_cnt = 0;
        end else if (en) begin
            if (m_phase == 0) begin
                if (ones == 1) begin
                    m_pos = idx; m_pv = 1; m_phase = 1;
                end else begin
                    m_err = 1; m_code = 1; m_phase = 3;
                end
            end else if (m_phase != 3) begin
                step = idx - m_pos;
                if (m_phase == 1) ok = (step == 1 || step == -1);
                else begin
                    if (m_pos == N - 1) want = -1;
                    else if (m_pos == 0) want = 1;
                    else want = m_dir ? 1 : -1;
                    ok = (step == want);
                end
                if (ones != 1) begin
                    m_err = 1; m_code = 1; m_pv = 0; m_phase = 3;
                end else if (!ok) begin
                    m_err = 1; m_code = 2; m_pv = 0; m_phase = 3;
                end else begin
                    if (m_phase == 2 && (idx == 0 || idx == N - 1) &&
                        m_cnt < 255)
                        m_cnt++;
                    m_dir = step > 0;
                    m_pos = idx;
                    m_phase = 2;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pos"}, 32'(bus.pos), 32'(m_pos));
        chk({tag, ".pv"}, 32'(bus.pos_valid), 32'(m_pv));
        chk({tag, ".dir"}, 32'(bus.dir), 32'(m_dir));
        chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
        chk({tag, ".code"}, 32'(bus.err_code), 32'(m_code));
        chk({tag, ".cnt"}, 32'(bus.sweep_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input string tag, input bit en, input bit clr,
                         input logic [7:0] l);
        @(negedge clk);
        bus.en = en; bus.clr = clr; bus.leds = l;
        @(posedge clk);
        model_step(en, clr, l);
        #1;
        check_all(tag);
    endtask

    task automatic gen_step(input string tag, input bit en);
        logic [7:0] l;
        if (en) begin
            l = 8'(1) << gpos;
            if (gpos == N - 1) gdir = 0;
            else if (gpos == 0) gdir = 1;
            gpos = gdir ? gpos + 1 : gpos - 1;
        end else begin
            l = 8'($urandom);
        end
        drive(tag, en, 1'b0, l);
    endtask

    task automatic gen_set(input int p, input int d);
        gpos = p; gdir = d;
    endtask

    initial begin
        logic [7:0] l;
        int r;
        bus.en = 1'b0; bus.clr = 1'b0; bus.leds = '0;
        model_reset();
        gen_set(0, 1);
        arst = 1'b1;
        #12;
        check_all("reset");
        arst = 1'b0;

        // full bounce 0..7..0,1
        for (int i = 0; i < 16; i++) begin
            gen_step("sweep", 1'b1);
            if (i == 8) chk("sweep_dir_down", 32'(bus.dir), 0);
            if (i == 15) chk("sweep_dir_up", 32'(bus.dir), 1);
        end
        chk("sweep_cnt2", 32'(bus.sweep_cnt), 2);
        chk("sweep_noerr", 32'(bus.err), 0);

        // en gaps while at pos 3 going up
        gen_step("gap", 1'b1);
        gen_step("gap", 1'b1);
        chk("gap_pos3", 32'(bus.pos), 3);
        gen_step("gap_en0", 1'b0);
        gen_step("gap_en0", 1'b0);
        chk("gap_hold", 32'(bus.pos), 3);
        gen_step("gap_resume", 1'b1);
        chk("gap_pos4", 32'(bus.pos), 4);
        chk("gap_noerr", 32'(bus.err), 0);

        // zero word then two-hot word in TRACK
        drive("zero", 1'b1, 1'b0, 8'h00);
        chk("zero_code", 32'(bus.err_code), 1);
        chk("zero_pv", 32'(bus.pos_valid), 0);
        for (int i = 0; i < 3; i++) gen_step("zero_ign", 1'b1);
        drive("clr", 1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 4; i++) gen_step("resync", 1'b1);
        drive("twohot", 1'b1, 1'b0, 8'h18);
        chk("twohot_code", 32'(bus.err_code), 1);
        gen_step("twohot_ign", 1'b1);

        // jump 2 -> 4
        drive("clr", 1'b1, 1'b1, 8'h00);
        gen_set(0, 1);
        for (int i = 0; i < 3; i++) gen_step("jump_pre", 1'b1);
        drive("jump", 1'b1, 1'b0, 8'h10);
        chk("jump_code", 32'(bus.err_code), 2);
        chk("jump_pos", 32'(bus.pos), 2);

        // dwell at 7
        drive("clr", 1'b1, 1'b1, 8'h00);
        gen_set(5, 1);
        for (int i = 0; i < 3; i++) gen_step("dwell_pre", 1'b1);
        drive("dwell", 1'b1, 1'b0, 8'h80);
        chk("dwell_code", 32'(bus.err_code), 2);
        chk("dwell_pos", 32'(bus.pos), 7);

        // clr with en in FAULT discards the sample
        drive("fclr", 1'b1, 1'b1, 8'h04);
        chk("fclr_err", 32'(bus.err), 0);
        chk("fclr_pv", 32'(bus.pos_valid), 0);

        // saturation over 300 bounces
        gen_set(0, 1);
        for (int i = 0; i < 300 * (N - 1) + 2; i++) gen_step("sat", 1'b1);
        chk("sat_cnt", 32'(bus.sweep_cnt), 255);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 arst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        arst = 1'b0;
        gen_set(0, 1);

        // randomized traffic with injected faults and clears
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                drive("rnd_clr", 1'($urandom), 1'b1, 8'($urandom));
            end else if (r < 5) begin
                l = 8'($urandom);
                drive("rnd_junk", 1'b1, 1'b0, l);
            end else if (r < 7) begin
                l = 8'(1) << $urandom_range(0, N - 1);
                drive("rnd_hot", 1'b1, 1'b0, l);
            end else begin
                gen_step("rnd", ($urandom_range(0, 3) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
